// File: rtl/pueo_time_sync_pkg.sv
// pueo_time_sync_pkg
// Shared types and helpers for the PPS time-sync sequencer.
//   state_e     : 3-bit FSM state encoding (IDLE=0 .. FAULT=6)
//   period_ok() : tolerance check of a measured PPS period
// The optional statistics outputs are controlled by the macro
// PUEO_TIME_SYNC_STATS_EN.
package pueo_time_sync_pkg;

  localparam int TIME_W  = 32;  // sysclk time counter / period width
  localparam int CNT_W   = 4;   // good/miss counters (limits 1..15)
  localparam int STATS_W = 16;  // optional saturating period counters

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_MEASURE = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_LOAD    = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_FAULT   = 3'd6
  } state_e;

  // Absolute difference first, then an unsigned compare, so periods on
  // either side of nominal are treated symmetrically.
  function automatic logic period_ok(input logic [TIME_W-1:0] period,
                                     input logic [TIME_W-1:0] nom,
                                     input logic [TIME_W-1:0] tol);
    logic [TIME_W-1:0] diff;
    diff = (period >= nom) ? (period - nom) : (nom - period);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/pueo_pps_period_check.sv
// pueo_pps_period_check
// Measures external PPS periods against the free-running sysclk time
// count and emits one-cycle good/bad verdicts.
// Ports:
//   sys_clk_i, sys_rst_i : clock, synchronous active-high reset
//   run_i                : measurement enabled; low clears the "have a
//                          previous edge" flag so the next edge only
//                          re-references t_prev
//   edge_i               : raw external PPS rising-edge pulse
//   cur_time_i           : free-running sysclk time counter
//   good_o / bad_o       : registered one-cycle verdict pulses
//   period_o             : last measured period (only when
//                          PUEO_TIME_SYNC_STATS_EN is defined)
module pueo_pps_period_check
  import pueo_time_sync_pkg::*;
#(
  parameter int unsigned NOM_PERIOD = 125000000,
  parameter int unsigned TOL        = 1250
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              run_i,
  input  logic              edge_i,
  input  logic [TIME_W-1:0] cur_time_i,
  output logic              good_o,
  output logic              bad_o
`ifdef PUEO_TIME_SYNC_STATS_EN
  ,
  output logic [TIME_W-1:0] period_o
`endif
);

  localparam logic [TIME_W-1:0] NOM_L    = TIME_W'(NOM_PERIOD);
  localparam logic [TIME_W-1:0] TOL_L    = TIME_W'(TOL);
  localparam logic [TIME_W-1:0] WD_LIMIT = TIME_W'(NOM_PERIOD + TOL);

  logic [TIME_W-1:0] t_prev_q, t_prev_d;
  logic [TIME_W-1:0] wd_base_q, wd_base_d;
  logic [TIME_W-1:0] period_q, period_d;
  logic              valid_q, valid_d;
  logic              good_q, good_d;
  logic              bad_q, bad_d;
  logic [TIME_W-1:0] meas_period;
  logic [TIME_W-1:0] wd_elapsed;

  // Modulo subtraction keeps both values correct across counter wrap.
  // The watchdog is measured in the same time base, so it is simply the
  // elapsed count since the last edge or the last watchdog restart.
  assign meas_period = cur_time_i - t_prev_q;
  assign wd_elapsed  = cur_time_i - wd_base_q;

  always_comb begin
    t_prev_d  = t_prev_q;
    wd_base_d = wd_base_q;
    period_d  = period_q;
    valid_d   = valid_q;
    good_d    = 1'b0;
    bad_d     = 1'b0;
    if (!run_i) begin
      valid_d = 1'b0;
    end else if (edge_i) begin
      // An edge wins over a simultaneous watchdog expiry.
      t_prev_d  = cur_time_i;
      wd_base_d = cur_time_i;
      valid_d   = 1'b1;
      if (valid_q) begin
        period_d = meas_period;
        if (period_ok(meas_period, NOM_L, TOL_L)) good_d = 1'b1;
        else                                      bad_d  = 1'b1;
      end
    end else if (valid_q && (wd_elapsed > WD_LIMIT)) begin
      bad_d     = 1'b1;
      wd_base_d = cur_time_i;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      t_prev_q  <= '0;
      wd_base_q <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      t_prev_q  <= t_prev_d;
      wd_base_q <= wd_base_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

  assign good_o = good_q;
  assign bad_o  = bad_q;
`ifdef PUEO_TIME_SYNC_STATS_EN
  assign period_o = period_q;
`endif

endmodule

// File: rtl/pueo_time_sync_ctrl.sv
// pueo_time_sync_ctrl
// Sequencer moving the PPS datapath from internal to a qualified external
// PPS, issuing one PPS-aligned second load, then monitoring lock.
// Ports:
//   sys_clk_i, sys_rst_i  : clock, synchronous active-high reset
//   start_i / abort_i     : command pulses (abort has priority)
//   target_sec_i          : second value, latched on an accepted start
//   pps_flag_i            : PPS flag from the time core
//   ext_pps_edge_i        : raw external PPS rising-edge pulse
//   cur_time_i            : free-running sysclk time counter
//   use_ext_pps_o         : PPS source select (1 = external)
//   load_sec_o/update_sec_o : second-load strobe and value
//   locked_o / fault_o    : status; fault is sticky until start/abort/reset
//   state_o               : current FSM state code
// Optional (macro PUEO_TIME_SYNC_STATS_EN): good_periods_o, bad_periods_o
// (saturating, cleared on start) and last_period_o.
module pueo_time_sync_ctrl
  import pueo_time_sync_pkg::*;
#(
  parameter int unsigned NOM_PERIOD = 125000000,
  parameter int unsigned TOL        = 1250,
  parameter int unsigned GOOD_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [TIME_W-1:0] target_sec_i,
  input  logic              pps_flag_i,
  input  logic              ext_pps_edge_i,
  input  logic [TIME_W-1:0] cur_time_i,
  output logic              use_ext_pps_o,
  output logic              load_sec_o,
  output logic [TIME_W-1:0] update_sec_o,
  output logic              locked_o,
  output logic              fault_o,
  output logic [2:0]        state_o
`ifdef PUEO_TIME_SYNC_STATS_EN
  ,
  output logic [STATS_W-1:0] good_periods_o,
  output logic [STATS_W-1:0] bad_periods_o,
  output logic [TIME_W-1:0]  last_period_o
`endif
);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] target_q, target_d;
  logic [TIME_W-1:0] update_q, update_d;
  logic [CNT_W-1:0]  good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              use_ext_q, use_ext_d;
  logic              load_q, load_d;
  logic              locked_q, locked_d;
  logic              fault_q, fault_d;

  logic              run;
  logic              start_ok;
  logic              per_good;
  logic              per_bad;
  logic [CNT_W-1:0]  good_inc;
  logic [CNT_W-1:0]  miss_inc;

  // Measurement is live from ARM through LOCKED; leaving it drops the
  // reference so the first edge after re-arming only sets t_prev.
  assign run      = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign start_ok = start_i && !abort_i &&
                    ((state_q == ST_IDLE) || (state_q == ST_FAULT));
  assign good_inc = good_cnt_q + 1'b1;
  assign miss_inc = miss_cnt_q + 1'b1;

  pueo_pps_period_check #(
    .NOM_PERIOD (NOM_PERIOD),
    .TOL        (TOL)
  ) u_period_check (
    .sys_clk_i  (sys_clk_i),
    .sys_rst_i  (sys_rst_i),
    .run_i      (run),
    .edge_i     (ext_pps_edge_i),
    .cur_time_i (cur_time_i),
    .good_o     (per_good),
    .bad_o      (per_bad)
`ifdef PUEO_TIME_SYNC_STATS_EN
    ,
    .period_o   (last_period_o)
`endif
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    update_d   = update_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    use_ext_d  = use_ext_q;
    load_d     = 1'b0;
    locked_d   = locked_q;
    fault_d    = fault_q;

    if (abort_i) begin
      state_d    = ST_IDLE;
      use_ext_d  = 1'b0;
      locked_d   = 1'b0;
      fault_d    = 1'b0;
      good_cnt_d = '0;
      miss_cnt_d = '0;
    end else if (start_ok) begin
      state_d    = ST_ARM;
      target_d   = target_sec_i;
      fault_d    = 1'b0;
      use_ext_d  = 1'b0;
      locked_d   = 1'b0;
      good_cnt_d = '0;
      miss_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          use_ext_d = 1'b0;
        end
        ST_ARM: begin
          if (ext_pps_edge_i) state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (per_good) begin
            if (good_inc == CNT_W'(GOOD_COUNT)) begin
              state_d    = ST_SWITCH;
              use_ext_d  = 1'b1;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_inc;
            end
          end else if (per_bad) begin
            good_cnt_d = '0;
          end
        end
        ST_SWITCH: begin
          // The first flag after switching may still belong to the old
          // source; the load waits for the following one.
          if (pps_flag_i) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          // Strobe lands the cycle after the flag so the core's own
          // second increment cannot overwrite the loaded value.
          if (pps_flag_i) begin
            state_d    = ST_LOCKED;
            load_d     = 1'b1;
            update_d   = target_q;
            locked_d   = 1'b1;
            miss_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (per_good) begin
            miss_cnt_d = '0;
          end else if (per_bad) begin
            if (miss_inc == CNT_W'(MISS_LIMIT)) begin
              state_d    = ST_FAULT;
              use_ext_d  = 1'b0;
              locked_d   = 1'b0;
              fault_d    = 1'b1;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end
        ST_FAULT: begin
          use_ext_d = 1'b0;
          locked_d  = 1'b0;
        end
        default: begin
          state_d   = ST_IDLE;
          use_ext_d = 1'b0;
          locked_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      update_q   <= '0;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
      use_ext_q  <= 1'b0;
      load_q     <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      update_q   <= update_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      use_ext_q  <= use_ext_d;
      load_q     <= load_d;
      locked_q   <= locked_d;
      fault_q    <= fault_d;
    end
  end

`ifdef PUEO_TIME_SYNC_STATS_EN
  logic [STATS_W-1:0] good_periods_q;
  logic [STATS_W-1:0] bad_periods_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || start_ok) begin
      good_periods_q <= '0;
      bad_periods_q  <= '0;
    end else begin
      if (per_good && (good_periods_q != '1)) good_periods_q <= good_periods_q + 1'b1;
      if (per_bad  && (bad_periods_q  != '1)) bad_periods_q  <= bad_periods_q + 1'b1;
    end
  end

  assign good_periods_o = good_periods_q;
  assign bad_periods_o  = bad_periods_q;
`endif

  assign use_ext_pps_o = use_ext_q;
  assign load_sec_o    = load_q;
  assign update_sec_o  = update_q;
  assign locked_o      = locked_q;
  assign fault_o       = fault_q;
  assign state_o       = state_q;

endmodule
